// File: rtl/gpr_write_queue.sv
// Write-back FIFO feeding the single GPR write port, with a pending-write bypass lookup.
// Optional bypass logic is built only when GPR_WQ_BYPASS_EN is defined.
module gpr_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  input  logic                     drain_hold,
  output logic                     SIG_RF_W,
  output logic [4:0]               reg_write,
  output logic [31:0]              data_write,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [4:0]               byp_addr1,
  input  logic [4:0]               byp_addr2,
  output logic                     byp_hit1,
  output logic                     byp_hit2,
  output logic [31:0]              byp_data1,
  output logic [31:0]              byp_data2
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;
  logic          full_s, empty_s, push_s, pop_s;

  assign full_s     = (count_q == (AW+1)'(DEPTH));
  assign empty_s    = (count_q == '0);
  // Register-0 writes complete the handshake but never occupy an entry.
  assign push_s     = wb_valid & ~full_s & (wb_addr != 5'd0);
  assign pop_s      = ~empty_s & ~drain_hold;

  assign wb_ready   = ~full_s;
  assign empty      = empty_s;
  assign count      = count_q;
  assign SIG_RF_W   = wr_q;
  assign reg_write  = waddr_q;
  assign data_write = wdata_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      head_d = head_q + AW'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = tail_q + AW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wr_q    <= pop_s;
      if (pop_s) begin
        waddr_q <= addr_mem_q[head_q];
        wdata_q <= data_mem_q[head_q];
      end
    end
  end

  // Entry storage needs no reset: only slots covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[tail_q] <= wb_addr;
      data_mem_q[tail_q] <= wb_data;
    end
  end

`ifdef GPR_WQ_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins; output register is oldest.
  function automatic logic [32:0] byp_lookup(input logic [4:0] a);
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = 33'd0;
    if (a != 5'd0) begin
      if (wr_q && (waddr_q == a)) r = {1'b1, wdata_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + AW'(i);
        if (((AW+1)'(i) < count_q) && (addr_mem_q[idx] == a)) r = {1'b1, data_mem_q[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = byp_lookup(byp_addr1);
    {byp_hit2, byp_data2} = byp_lookup(byp_addr2);
  end
`else
  logic byp_unused_s;
  assign byp_unused_s = &{1'b0, byp_addr1, byp_addr2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = 32'd0;
  assign byp_data2 = 32'd0;
`endif
endmodule

// File: tb/tb_gpr_write_queue.sv
// Directed bench for gpr_write_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal checks for the main scenarios.
module tb_gpr_write_queue;
  localparam int DEPTH = 4;

  logic        clk, rst, wb_valid, wb_ready, drain_hold, SIG_RF_W, empty;
  logic [4:0]  wb_addr, reg_write, byp_addr1, byp_addr2;
  logic [31:0] wb_data, data_write, byp_data1, byp_data2;
  logic [2:0]  count;
  logic        byp_hit1, byp_hit2;

  gpr_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .drain_hold(drain_hold),
    .SIG_RF_W(SIG_RF_W), .reg_write(reg_write), .data_write(data_write),
    .empty(empty), .count(count),
    .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for the gpr register file, fed from the DUT write port.
  logic [31:0] gpr_tb [32];
  int          commits = 0;
  always @(posedge clk) begin
    if (!rst && SIG_RF_W) begin
      gpr_tb[reg_write] <= data_write;
      commits <= commits + 1;
    end
  end

  // Reference model: a plain queue of pending writes plus the in-flight write port.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_w;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit m_accept();
    return wb_valid && (mq.size() < DEPTH) && (wb_addr != 5'd0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_w    <= 1'b0;
      m_addr <= 5'd0;
      m_data <= 32'd0;
    end else if (mq.size() > 0 && !drain_hold) begin
      m_w    <= 1'b1;
      m_addr <= mq[0].a;
      m_data <= mq[0].d;
      if (m_accept()) mq.push_back('{a: wb_addr, d: wb_data});
      void'(mq.pop_front());
    end else begin
      m_w <= 1'b0;
      if (m_accept()) mq.push_back('{a: wb_addr, d: wb_data});
    end
  end

  function automatic logic [32:0] m_byp(input logic [4:0] a);
`ifdef GPR_WQ_BYPASS_EN
    if (a == 5'd0) return 33'd0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == a) return {1'b1, mq[i].d};
    if (m_w && m_addr == a) return {1'b1, m_data};
`endif
    return 33'd0;
  endfunction

  logic [32:0] e1, e2;
  always @(negedge clk) begin
    e1 = m_byp(byp_addr1);
    e2 = m_byp(byp_addr2);
    chk("wb_ready",  {31'd0, wb_ready}, {31'd0, mq.size() < DEPTH});
    chk("empty",     {31'd0, empty},    {31'd0, mq.size() == 0});
    chk("count",     {29'd0, count},    mq.size());
    chk("SIG_RF_W",  {31'd0, SIG_RF_W}, {31'd0, m_w});
    chk("reg_write", {27'd0, reg_write}, {27'd0, m_addr});
    chk("data_write", data_write, m_data);
    chk("byp_hit1",  {31'd0, byp_hit1}, {31'd0, e1[32]});
    chk("byp_data1", byp_data1, e1[31:0]);
    chk("byp_hit2",  {31'd0, byp_hit2}, {31'd0, e2[32]});
    chk("byp_data2", byp_data2, e2[31:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef GPR_WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int c_snap;

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    drain_hold = 1'b0; byp_addr1 = 5'd0; byp_addr2 = 5'd0;
    for (int i = 0; i < 32; i++) gpr_tb[i] = 32'd0;
    step(); step();
    chk("rst_SIG_RF_W", {31'd0, SIG_RF_W}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, wb_ready}, 32'd1);
    rst = 1'b0;

    // Single write with latency check.
    byp_addr1 = 5'd5; byp_addr2 = 5'd6;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    step();
    wb_valid = 1'b0;
    chk("single_E_wr", {31'd0, SIG_RF_W}, 32'd0);
    chk("single_E_hit", {31'd0, byp_hit1}, {31'd0, BYP});
    step();
    chk("single_E1_wr", {31'd0, SIG_RF_W}, 32'd1);
    chk("single_E1_addr", {27'd0, reg_write}, 32'd5);
    chk("single_E1_data", data_write, 32'h1234_5678);
    step();
    chk("single_E2_wr", {31'd0, SIG_RF_W}, 32'd0);
    chk("single_gpr5", gpr_tb[5], 32'h1234_5678);
    chk("single_E2_hit", {31'd0, byp_hit1}, 32'd0);

    // Register 0 writes are discarded.
    byp_addr1 = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    step();
    wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("r0_count", {29'd0, count}, 32'd0);
      chk("r0_wr", {31'd0, SIG_RF_W}, 32'd0);
      chk("r0_hit", {31'd0, byp_hit1}, 32'd0);
      step();
    end

    // Fill with hold: five requests, four accepted.
    drain_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(k + 1); wb_data = 32'h100 + 32'(k);
      step();
      if (k == 3) begin
        chk("fill_count", {29'd0, count}, 32'd4);
        chk("fill_ready", {31'd0, wb_ready}, 32'd0);
      end
    end
    wb_valid = 1'b0; drain_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_wr", {31'd0, SIG_RF_W}, 32'd1);
      chk("drain_addr", {27'd0, reg_write}, 32'(k + 1));
      chk("drain_data", data_write, 32'h100 + 32'(k));
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);
    step();
    chk("drain_done_wr", {31'd0, SIG_RF_W}, 32'd0);

    // Youngest-wins bypass.
    drain_hold = 1'b1; byp_addr1 = 5'd7; byp_addr2 = 5'd4;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hA;
    step();
    wb_data = 32'hB;
    step();
    wb_valid = 1'b0;
    chk("yw_hit", {31'd0, byp_hit1}, {31'd0, BYP});
    chk("yw_data", byp_data1, BYP ? 32'hB : 32'h0);
    drain_hold = 1'b0;
    step();
    chk("yw_pop1_data", byp_data1, BYP ? 32'hB : 32'h0);
    step();
    chk("yw_pop2_hit", {31'd0, byp_hit1}, {31'd0, BYP});
    step();
    chk("yw_commit_hit", {31'd0, byp_hit1}, 32'd0);
    chk("yw_gpr7", gpr_tb[7], 32'hB);

    // Continuous streaming, then reset mid-stream.
    for (int k = 0; k < 10; k++) begin
      wb_valid = 1'b1; wb_addr = 5'(k + 10); wb_data = 32'hC000_0000 + 32'(k);
      byp_addr1 = 5'(k + 10); byp_addr2 = 5'(k + 9);
      step();
      if (k >= 1) begin
        chk("stream_count", {29'd0, count}, 32'd1);
        chk("stream_wr", {31'd0, SIG_RF_W}, 32'd1);
        chk("stream_data", data_write, 32'hC000_0000 + 32'(k - 1));
      end
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", {31'd0, SIG_RF_W}, 32'd0);
    chk("rst_mid_count", {29'd0, count}, 32'd0);
    c_snap = commits;
    step(); step();
    rst = 1'b0; wb_valid = 1'b0;
    step(); step(); step();
    chk("rst_no_commit", commits, c_snap);
    chk("rst_empty", {31'd0, empty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
